// File: rtl/sudoku_draw_pkg.sv
// Shared types for the Sudoku object-drawing path: cell command record,
// repaint FSM states and grid dimensions.
package sudoku_draw_pkg;

  localparam int unsigned GRID_N = 9;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
    logic [2:0] color;
  } cell_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT
  } paint_state_t;

  function automatic logic cell_idx_ok(input cell_cmd_t c);
    return (c.row < 4'(GRID_N)) && (c.col < 4'(GRID_N));
  endfunction

endpackage

// File: rtl/cell_cmd_fifo.sv
// Synchronous FIFO of cell repaint commands; DEPTH must be a power of two.
module cell_cmd_fifo
  import sudoku_draw_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  cell_cmd_t                wdata,
  input  logic                     pop,
  output cell_cmd_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  cell_cmd_t        mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cell_paint_queue.sv
// Queues Sudoku cell repaint requests (and full-board clear sweeps) and hands
// them to the square drawer one absolute-coordinate square at a time.
module cell_paint_queue
  import sudoku_draw_pkg::*;
#(
  parameter logic [10:0] ORIGIN_X    = 11'd100,
  parameter logic [10:0] ORIGIN_Y    = 11'd20,
  parameter logic [10:0] CELL_W      = 11'd40,
  parameter logic [10:0] GAP         = 11'd2,
  parameter int unsigned DEPTH       = 8,
  parameter logic [2:0]  CLEAR_COLOR = 3'b111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [3:0]  upd_row,
  input  logic [3:0]  upd_col,
  input  logic [2:0]  upd_color,
  input  logic        clear_req,
  output logic        sq_start,
  output logic [10:0] sq_x0,
  output logic [10:0] sq_y0,
  output logic [10:0] sq_x1,
  output logic [10:0] sq_y1,
  output logic [2:0]  sq_color,
  input  logic        sq_done,
  output logic        busy,
  output logic        err_sticky
);

  paint_state_t             state, state_next;
  cell_cmd_t                cmd;
  cell_cmd_t                push_cmd;
  cell_cmd_t                fifo_head;
  logic                     fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     fifo_push, fifo_pop;
  logic                     clear_pend, sweeping, sweep_last;
  logic                     start_sweep, sweep_step, sweep_end;
  logic                     done_ok, load_coords, start_next;
  logic [10:0]              x0_calc, y0_calc, span;

  assign push_cmd  = '{row: upd_row, col: upd_col, color: upd_color};
  assign upd_ready = !fifo_full;
  assign fifo_push = upd_valid && upd_ready;
  assign busy      = (state != IDLE) || (fifo_count != '0);

  cell_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (push_cmd),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // sq_start is registered, so a done coinciding with it belongs to the previous square
  assign done_ok    = sq_done && !sq_start;
  assign sweep_last = (cmd.row == 4'(GRID_N - 1)) && (cmd.col == 4'(GRID_N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clear_pend)
          state_next = LOAD;
        else if (!fifo_empty && cell_idx_ok(fifo_head))
          state_next = LOAD;
      end
      LOAD:    state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (done_ok) state_next = (sweeping && !sweep_last) ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_sweep = (state == IDLE) && clear_pend;
    fifo_pop    = (state == IDLE) && !clear_pend && !fifo_empty;
    sweep_step  = (state == WAIT) && done_ok && sweeping && !sweep_last;
    sweep_end   = (state == WAIT) && done_ok && sweeping && sweep_last;
    load_coords = (state == LOAD);
    start_next  = (state == ISSUE);
  end

  always_comb begin
    span    = CELL_W - 11'd1 - (GAP << 1);
    x0_calc = ORIGIN_X + 11'(cmd.col) * CELL_W + GAP;
    y0_calc = ORIGIN_Y + 11'(cmd.row) * CELL_W + GAP;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd        <= '0;
      clear_pend <= 1'b0;
      sweeping   <= 1'b0;
      err_sticky <= 1'b0;
      sq_start   <= 1'b0;
      sq_x0      <= '0;
      sq_y0      <= '0;
      sq_x1      <= '0;
      sq_y1      <= '0;
      sq_color   <= '0;
    end else begin
      sq_start <= start_next;
      if (fifo_push && !cell_idx_ok(push_cmd)) err_sticky <= 1'b1;

      // a clear arriving while a sweep is running or just starting is absorbed by it
      if (start_sweep)                  clear_pend <= 1'b0;
      else if (clear_req && !sweeping)  clear_pend <= 1'b1;

      if (start_sweep)    sweeping <= 1'b1;
      else if (sweep_end) sweeping <= 1'b0;

      if (start_sweep) begin
        cmd <= '{row: '0, col: '0, color: CLEAR_COLOR};
      end else if (fifo_pop && cell_idx_ok(fifo_head)) begin
        cmd <= fifo_head;
      end else if (sweep_step) begin
        if (cmd.col == 4'(GRID_N - 1)) begin
          cmd.col <= '0;
          cmd.row <= cmd.row + 4'd1;
        end else begin
          cmd.col <= cmd.col + 4'd1;
        end
      end

      if (load_coords) begin
        sq_x0    <= x0_calc;
        sq_y0    <= y0_calc;
        sq_x1    <= x0_calc + span;
        sq_y1    <= y0_calc + span;
        sq_color <= cmd.color;
      end
    end
  end

endmodule

// File: tb/tb_cell_paint_queue.sv
// Directed self-checking bench for cell_paint_queue with default parameters.
module tb_cell_paint_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_valid;
  logic        upd_ready;
  logic [3:0]  upd_row;
  logic [3:0]  upd_col;
  logic [2:0]  upd_color;
  logic        clear_req;
  logic        sq_start;
  logic [10:0] sq_x0, sq_y0, sq_x1, sq_y1;
  logic [2:0]  sq_color;
  logic        sq_done;
  logic        busy;
  logic        err_sticky;
  logic [46:0] sq_all;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign sq_all = {sq_x0, sq_y0, sq_x1, sq_y1, sq_color};

  cell_paint_queue dut (
    .clk        (clk),
    .reset      (reset),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_row    (upd_row),
    .upd_col    (upd_col),
    .upd_color  (upd_color),
    .clear_req  (clear_req),
    .sq_start   (sq_start),
    .sq_x0      (sq_x0),
    .sq_y0      (sq_y0),
    .sq_x1      (sq_x1),
    .sq_y1      (sq_y1),
    .sq_color   (sq_color),
    .sq_done    (sq_done),
    .busy       (busy),
    .err_sticky (err_sticky)
  );

  // Expected square for cell (r,c): origin 100/20, pitch 40, inset 2, side 36.
  function automatic logic [46:0] exp_sq(input int r, input int c, input int color);
    logic [10:0] x0, y0;
    x0 = 11'(100 + c * 40 + 2);
    y0 = 11'(20 + r * 40 + 2);
    return {x0, y0, x0 + 11'd35, y0 + 11'd35, 3'(color)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int maxc, output bit got, output int n);
    n = 0;
    while (!sq_start && n < maxc) begin
      cyc();
      n++;
    end
    got = sq_start;
  endtask

  task automatic done_after(input int d);
    repeat (d) cyc();
    sq_done = 1'b1;
    cyc();
    sq_done = 1'b0;
  endtask

  task automatic push_req(input int r, input int c, input int color);
    upd_row   = 4'(r);
    upd_col   = 4'(c);
    upd_color = 3'(color);
    upd_valid = 1'b1;
    cyc();
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; upd_valid = 1'b0; upd_row = '0; upd_col = '0; upd_color = '0;
    clear_req = 1'b0; sq_done = 1'b0;
    repeat (2) cyc();
    checks++;
    if ({upd_ready, sq_start, busy, err_sticky} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_flags ready/start/busy/err got %b exp 1000", {upd_ready, sq_start, busy, err_sticky});
    end
    checks++;
    if (sq_all !== 47'd0) begin
      fails++;
      $display("FAIL reset_fields got %h exp 0", sq_all);
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    bit got; int n;
    push_req(2, 3, 3'b010);
    wait_start(10, got, n);
    checks++;
    if (!(got && n == 3)) begin
      fails++;
      $display("FAIL single_latency got start=%0b after %0d cycles exp 1 after 3", got, n);
    end
    checks++;
    if (sq_all !== exp_sq(2, 3, 2)) begin
      fails++;
      $display("FAIL single_coords got %h exp %h", sq_all, exp_sq(2, 3, 2));
    end
    cyc();
    checks++;
    if (sq_start !== 1'b0 || sq_all !== exp_sq(2, 3, 2)) begin
      fails++;
      $display("FAIL single_hold got start=%0b fields=%h exp 0 and %h", sq_start, sq_all, exp_sq(2, 3, 2));
    end
    done_after(2);
    repeat (2) cyc();
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL single_idle busy got %0b exp 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    bit got; int n; int seen;
    push_req(0, 0, 5);
    push_req(8, 8, 1);
    wait_start(10, got, n);
    sq_done = 1'b1;
    cyc();
    sq_done = 1'b0;
    seen = 0;
    repeat (6) begin
      cyc();
      if (sq_start) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL done_with_start starts=%0d busy=%0b exp 0 starts busy 1", seen, busy);
    end
    done_after(1);
    wait_start(10, got, n);
    checks++;
    if (!(got && n == 3)) begin
      fails++;
      $display("FAIL b2b_spacing got start=%0b after %0d exp 1 after 3", got, n);
    end
    checks++;
    if (sq_all !== exp_sq(8, 8, 1)) begin
      fails++;
      $display("FAIL b2b_coords got %h exp %h", sq_all, exp_sq(8, 8, 1));
    end
    done_after(1);
    repeat (3) cyc();
  endtask

  task automatic test_burst();
    bit got; int n; int k; int acc;
    push_req(4, 4, 0);
    wait_start(10, got, n);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (upd_ready) acc++;
      push_req(i, 8 - i, i);
    end
    checks++;
    if (acc != 8 || upd_ready !== 1'b0) begin
      fails++;
      $display("FAIL burst_full accepted=%0d ready=%0b exp 8 and 0", acc, upd_ready);
    end
    upd_row = 4'd8; upd_col = 4'd0; upd_color = 3'd0; upd_valid = 1'b1;
    cyc();
    checks++;
    if (upd_ready !== 1'b0) begin
      fails++;
      $display("FAIL burst_ninth_held ready got %0b exp 0", upd_ready);
    end
    done_after(20);
    k = 0;
    while (!upd_ready && k < 10) begin
      cyc();
      k++;
    end
    checks++;
    if (upd_ready !== 1'b1) begin
      fails++;
      $display("FAIL burst_ready_after_pop ready got %0b exp 1", upd_ready);
    end
    cyc();
    upd_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wait_start(40, got, n);
      checks++;
      if (!got || sq_all !== exp_sq(i, 8 - i, i)) begin
        fails++;
        $display("FAIL burst_order[%0d] got start=%0b %h exp %h", i, got, sq_all, exp_sq(i, 8 - i, i));
      end
      done_after(20);
    end
    repeat (3) cyc();
  endtask

  task automatic test_clear();
    bit got; int n; int seen;
    push_req(1, 1, 1);
    wait_start(10, got, n);
    push_req(0, 5, 3);
    push_req(7, 2, 6);
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    done_after(1);
    for (int s = 0; s < 81; s++) begin
      wait_start(10, got, n);
      checks++;
      if (!got || n != ((s == 0) ? 3 : 2)) begin
        fails++;
        $display("FAIL sweep_timing[%0d] got start=%0b after %0d", s, got, n);
      end
      checks++;
      if (sq_all !== exp_sq(s / 9, s % 9, 7)) begin
        fails++;
        $display("FAIL sweep_coords[%0d] got %h exp %h", s, sq_all, exp_sq(s / 9, s % 9, 7));
      end
      if (s == 10) begin
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        sq_done = 1'b1;
        cyc();
        sq_done = 1'b0;
      end else begin
        done_after(1);
      end
    end
    wait_start(10, got, n);
    checks++;
    if (!got || sq_all !== exp_sq(0, 5, 3)) begin
      fails++;
      $display("FAIL after_sweep_a got start=%0b %h exp %h", got, sq_all, exp_sq(0, 5, 3));
    end
    done_after(1);
    wait_start(10, got, n);
    checks++;
    if (!got || sq_all !== exp_sq(7, 2, 6)) begin
      fails++;
      $display("FAIL after_sweep_b got start=%0b %h exp %h", got, sq_all, exp_sq(7, 2, 6));
    end
    done_after(1);
    seen = 0;
    repeat (12) begin
      cyc();
      if (sq_start) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL no_second_sweep starts=%0d busy=%0b exp 0 and 0", seen, busy);
    end
  endtask

  task automatic test_illegal();
    bit got; int n; int seen;
    checks++;
    if (err_sticky !== 1'b0) begin
      fails++;
      $display("FAIL err_before got %0b exp 0", err_sticky);
    end
    push_req(9, 0, 4);
    seen = 0;
    repeat (8) begin
      cyc();
      if (sq_start) seen++;
    end
    checks++;
    if (seen != 0 || err_sticky !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL illegal_drop starts=%0d err=%0b busy=%0b exp 0 1 0", seen, err_sticky, busy);
    end
    push_req(5, 6, 2);
    wait_start(10, got, n);
    checks++;
    if (!got || sq_all !== exp_sq(5, 6, 2)) begin
      fails++;
      $display("FAIL legal_after_illegal got start=%0b %h exp %h", got, sq_all, exp_sq(5, 6, 2));
    end
    done_after(1);
    repeat (3) cyc();
  endtask

  task automatic test_push_pop_count();
    bit got; int n;
    push_req(3, 3, 3);
    wait_start(10, got, n);
    for (int i = 0; i < 4; i++) push_req(0, i, 1);
    checks++;
    if (dut.fifo_count !== 4'd4) begin
      fails++;
      $display("FAIL count_before got %0d exp 4", dut.fifo_count);
    end
    sq_done = 1'b1;
    cyc();
    sq_done = 1'b0;
    push_req(6, 6, 6);
    checks++;
    if (dut.fifo_count !== 4'd4) begin
      fails++;
      $display("FAIL count_push_pop got %0d exp 4", dut.fifo_count);
    end
    for (int i = 0; i < 5; i++) begin
      wait_start(10, got, n);
      checks++;
      if (!got || sq_all !== ((i < 4) ? exp_sq(0, i, 1) : exp_sq(6, 6, 6))) begin
        fails++;
        $display("FAIL push_pop_order[%0d] got start=%0b %h", i, got, sq_all);
      end
      done_after(1);
    end
    repeat (3) cyc();
  endtask

  task automatic test_reset_mid();
    bit got; int n; int seen;
    push_req(2, 2, 2);
    wait_start(10, got, n);
    for (int i = 0; i < 3; i++) push_req(1, i, 4);
    reset = 1'b0;
    #1;
    checks++;
    if ({upd_ready, sq_start, busy, err_sticky} !== 4'b1000 || sq_all !== 47'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs flags=%b fields=%h exp 1000 and 0", {upd_ready, sq_start, busy, err_sticky}, sq_all);
    end
    checks++;
    if (dut.fifo_count !== 4'd0) begin
      fails++;
      $display("FAIL reset_mid_fifo count got %0d exp 0", dut.fifo_count);
    end
    cyc();
    reset = 1'b1;
    sq_done = 1'b1;
    cyc();
    sq_done = 1'b0;
    seen = 0;
    repeat (10) begin
      cyc();
      if (sq_start) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL late_done starts=%0d busy=%0b exp 0 and 0", seen, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_burst();
    test_clear();
    test_illegal();
    test_push_pop_count();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
